// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered 16-bit AND/OR/XOR/NAND unit among N_REQ requesters.
// Optional feature: define LU_ARB_ZERO_FLAG_EN to add the registered rsp_zero output.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*2-1:0]     req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id
`ifdef LU_ARB_ZERO_FLAG_EN
    ,
    output logic                   rsp_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    state_t           state, state_next;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic             grant_found;
    logic             accept;

    logic [WIDTH-1:0] lat_a, lat_b;
    op_t              lat_op;
    logic [IDW-1:0]   lat_g;
    logic [WIDTH-1:0] result;

    // Scan last_grant+1, +2, ... so the most recently served requester comes last.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDW'((int'(last_grant) + i) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grants are only offered in IDLE and are masked during the reset cycle.
    assign accept = (state == IDLE) && grant_found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        result = '0;
        case (lat_op)
            OP_AND:  result = lat_a & lat_b;
            OP_OR:   result = lat_a | lat_b;
            OP_XOR:  result = lat_a ^ lat_b;
            OP_NAND: result = ~(lat_a & lat_b);
            default: result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            last_grant <= IDW'(N_REQ - 1);
        end else begin
            case (state)
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= result;
                    rsp_id    <= lat_g;
                end
                RESP: begin
                    // Priority advances only once the consumer has taken the result.
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= lat_g;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LU_ARB_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_zero <= 1'b0;
        end else if (state == EXEC) begin
            rsp_zero <= (result == '0);
        end
    end
`endif

    // NOTE: the operand latches carry no reset; they are always rewritten on acceptance before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_a  <= req_a[grant_idx*WIDTH +: WIDTH];
            lat_b  <= req_b[grant_idx*WIDTH +: WIDTH];
            lat_op <= op_t'(req_op[grant_idx*2 +: 2]);
            lat_g  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table plus hand-written
// sequences for round-robin order, response back-pressure and mid-operation reset.
module tb_logic_unit_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;
    localparam int WAIT_LIMIT = 20;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*2-1:0]     req_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [IDW-1:0]         rsp_id;
`ifdef LU_ARB_ZERO_FLAG_EN
    logic                   rsp_zero;
`endif

    int passed = 0;
    int total  = 0;

    logic_unit_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef LU_ARB_ZERO_FLAG_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic set_operands(input int idx, input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] op);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_op[idx*2 +: 2]        = op;
    endtask

    // Called at a negedge; waits (bounded) until some grant is offered.
    task automatic wait_grant(input string name);
        int n = 0;
        while (req_ready == '0 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == '0) begin
            total++;
            $display("FAIL %s: no grant within %0d cycles", name, WAIT_LIMIT);
        end
    endtask

    // Called at the negedge where the grant is visible; completes with rsp_ready high.
    task automatic finish_op(input string name, input logic [IDW-1:0] exp_id,
                             input logic [15:0] exp_data, input logic chk_data);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check({name, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, " exec req_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, " rsp_id"}, 32'(rsp_id), 32'(exp_id));
        if (chk_data) begin
            check({name, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
`ifdef LU_ARB_ZERO_FLAG_EN
            check({name, " rsp_zero"}, 32'(rsp_zero), 32'(exp_data == 16'h0));
`endif
        end
        @(negedge clk);
        check({name, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 16'd3,      16'd3,      2'b00, 16'd3};
        vecs[1] = '{3, 16'hAAAA,   16'h5555,   2'b10, 16'hFFFF};
        vecs[2] = '{0, 16'd8,      16'd1,      2'b00, 16'h0000};
        vecs[3] = '{2, 16'd1,      16'd1,      2'b00, 16'h0001};
        vecs[4] = '{1, 16'd21,     16'd9,      2'b00, 16'd1};
        vecs[5] = '{1, 16'd21,     16'd9,      2'b01, 16'd29};
        vecs[6] = '{1, 16'd21,     16'd9,      2'b10, 16'd28};
        vecs[7] = '{1, 16'd21,     16'd9,      2'b11, 16'hFFFE};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_operands(i, 16'(i + 1), 16'hFFFF, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, with every requester asking during the reset cycle.
        req_valid = '1;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
`ifdef LU_ARB_ZERO_FLAG_EN
        check("reset rsp_zero", 32'(rsp_zero), 32'd0);
`endif
        rst = 1'b0;
        #1;

        // Round-robin order under continuous requests from all clients.
        for (int k = 0; k < 6; k++) begin
            wait_grant("rr grant");
            check($sformatf("rr grant %0d", k), 32'(req_ready), 32'(1 << (k % N_REQ)));
            @(negedge clk);
            check($sformatf("rr exec ready %0d", k), 32'(req_ready), 32'd0);
            @(negedge clk);
            check($sformatf("rr rsp_valid %0d", k), 32'(rsp_valid), 32'd1);
            check($sformatf("rr rsp_id %0d", k), 32'(rsp_id), 32'(k % N_REQ));
            check($sformatf("rr rsp_data %0d", k), 32'(rsp_data), 32'((k % N_REQ) + 1));
            if (k == 5) req_valid = '0;
            @(negedge clk);
        end
        check("rr idle after drop", 32'(req_ready), 32'd0);

        // Back-pressure: response held while others wait; next grant follows requester 2.
        set_operands(2, 16'h00FF, 16'h0F0F, 2'b00);
        set_operands(3, 16'h1234, 16'h00F0, 2'b01);
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        wait_grant("hold grant");
        check("hold grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1 req_valid = 4'b1011;
        @(negedge clk);
        check("hold exec ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold rsp_valid %0d", c), 32'(rsp_valid), 32'd1);
            check($sformatf("hold rsp_data %0d", c), 32'(rsp_data), 32'h000F);
            check($sformatf("hold rsp_id %0d", c), 32'(rsp_id), 32'd2);
            check($sformatf("hold req_ready %0d", c), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold next grant", 32'(req_ready), 32'b1000);
        finish_op("hold follow", 2'd3, 16'h12F4, 1'b1);

        // Single-requester vectors through the table.
        for (int v = 0; v < 8; v++) begin
            set_operands(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op);
            req_valid = 4'(1 << vecs[v].idx);
            #1;
            wait_grant($sformatf("vec %0d grant", v));
            check($sformatf("vec %0d grant", v), 32'(req_ready), 32'(1 << vecs[v].idx));
            finish_op($sformatf("vec %0d", v), IDW'(vecs[v].idx), vecs[v].exp_data, 1'b1);
        end

        // Reset during EXEC of requester 3: nothing emitted, priority back to requester 0.
        set_operands(3, 16'hFFFF, 16'hFFFF, 2'b00);
        req_valid = 4'b1000;
        #1;
        wait_grant("rst grant");
        check("rst grant req3", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        req_valid = '1;
        #1;
        check("rst priority", 32'(req_ready), 32'b0001);
        finish_op("post reset", 2'd0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
